// File: rtl/copper_exec_if.sv
// XR register write port of the copper engine: request/ack handshake
// carrying a 12-bit register address and 16-bit write data.
interface copper_exec_if;
  logic        xr_wr_en_o;
  logic        xr_ack_i;
  logic [11:0] xr_addr_o;
  logic [15:0] xr_data_o;

  modport master (output xr_wr_en_o, xr_addr_o, xr_data_o, input xr_ack_i);
  modport slave  (input xr_wr_en_o, xr_addr_o, xr_data_o, output xr_ack_i);
endinterface

// File: rtl/copper_exec.sv
// Copper execution engine: fetches 16-bit words from copper program memory,
// runs MOVE/WAIT/JUMP/NOP and issues XR register writes; restarts on EOF.
//
// state  | meaning
// IDLE   | engine disabled, pc held at 0
// FETCH  | pc on the read port
// DECODE | act on fetched opcode word
// FETCH2 | MOVE data word address on the read port
// DATA   | latch MOVE data, raise write request
// WRITE  | hold write request until acked
// WAIT   | stall on beam position (or until EOF)
module copper_exec #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              copp_en_i,
  input  logic              eof_i,
  input  logic [10:0]       h_count_i,
  input  logic [10:0]       v_count_i,
  output logic [AWIDTH-1:0] rd_address_o,
  input  logic [15:0]       rd_data_i,
  copper_exec_if.master     xr
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_DATA, S_WRITE, S_WAIT
  } state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] pc_q;
  logic              wr_en_q;
  logic [11:0]       xr_addr_q;
  logic [15:0]       xr_data_q;
  logic [10:0]       wait_tgt_q;
  logic              wait_v_q;
  logic              wait_eof_q;

  logic [AWIDTH-1:0] pc_inc_d;
  logic              wait_hit_d;

  assign pc_inc_d = pc_q + AWIDTH'(1);

  // The wait-for-EOF word would otherwise be satisfiable late in the frame.
  assign wait_hit_d = !wait_eof_q &&
                      (wait_v_q ? (v_count_i >= wait_tgt_q) : (h_count_i >= wait_tgt_q));

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      wr_en_q    <= 1'b0;
      xr_addr_q  <= '0;
      xr_data_q  <= '0;
      wait_tgt_q <= '0;
      wait_v_q   <= 1'b0;
      wait_eof_q <= 1'b0;
    end else if (!copp_en_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      wr_en_q   <= 1'b0;
      xr_addr_q <= '0;
      xr_data_q <= '0;
    end else if (state_q == S_IDLE) begin
      state_q <= S_FETCH;
    end else if (eof_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (rd_data_i[15:12])
            4'h0: begin
              xr_addr_q <= rd_data_i[11:0];
              pc_q      <= pc_inc_d;
              state_q   <= S_FETCH2;
            end
            4'h2: begin
              wait_tgt_q <= rd_data_i[10:0];
              wait_v_q   <= rd_data_i[11];
              wait_eof_q <= (rd_data_i == 16'h2BFF);
              state_q    <= S_WAIT;
            end
            4'h4: begin
              pc_q    <= rd_data_i[AWIDTH-1:0];
              state_q <= S_FETCH;
            end
            default: begin
              pc_q    <= pc_inc_d;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_FETCH2: state_q <= S_DATA;
        S_DATA: begin
          xr_data_q <= rd_data_i;
          pc_q      <= pc_inc_d;
          wr_en_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (xr.xr_ack_i) begin
            wr_en_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (wait_hit_d) begin
            pc_q    <= pc_inc_d;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_address_o  = pc_q;
  assign xr.xr_wr_en_o = wr_en_q;
  assign xr.xr_addr_o  = xr_addr_q;
  assign xr.xr_data_o  = xr_data_q;

endmodule
